spike_window_capture: RTL

//  Samples a serial spike line over a LEN-cycle time window and assembles the LEN-bit

---
 rtl/spike_pkg.sv | 16 +
 rtl/spike_window_capture_encoder.sv | 27 ++
 rtl/spike_window_capture.sv | 128 ++++++++++++
 3 files changed

// File: rtl/spike_pkg.sv
// rtl/spike_pkg.sv - shared types and helpers for the spike window capture block
//   cap_state_t : capture FSM states (IDLE, CAPTURE, HOLD)
//   shift_w(m)  : signed width needed to carry a shift request of magnitude up to m
package spike_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } cap_state_t;

    function automatic int shift_w(input int max_mag);
        return $clog2(max_mag + 1) + 1;
    endfunction

endpackage

// File: rtl/spike_window_capture_encoder.sv
// rtl/spike_window_capture_encoder.sv - signed shift request to saturated one-hot word
//   shift_in : signed shift request (SW bits)
//   onehot   : [0:2*MAX_SHIFT_MAG], bit MAX_SHIFT_MAG+s set, s clamped to +/-MAX_SHIFT_MAG
module onehot_shift_encoder
    import spike_pkg::*;
#(
    parameter  int MAX_SHIFT_MAG = 2,
    localparam int SW            = shift_w(MAX_SHIFT_MAG)
) (
    input  logic signed [SW-1:0]          shift_in,
    output logic [0:2*MAX_SHIFT_MAG]      onehot
);

    always_comb begin
        int sat;
        sat = int'(shift_in);
        if (sat > MAX_SHIFT_MAG) begin
            sat = MAX_SHIFT_MAG;
        end else if (sat < -MAX_SHIFT_MAG) begin
            sat = -MAX_SHIFT_MAG;
        end
        for (int i = 0; i <= 2 * MAX_SHIFT_MAG; i++) begin
            onehot[i] = (i == sat + MAX_SHIFT_MAG);
        end
    end

endmodule

// File: rtl/spike_window_capture.sv
// rtl/spike_window_capture.sv - serial spike window capture with one-hot shift output
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a window (taken only when start_rdy=1)
//   spike_in   : serial spike line, sampled once per capture cycle
//   shift_req  : signed shift request, latched with an accepted start
//   start_rdy  : start can be accepted this cycle
//   win        : [0:LEN-1] captured vector, offset t lands in win[LEN-1-t]
//   shift_mag  : [0:2*MAX_SHIFT_MAG] saturated one-hot shift
//   win_valid  : win/shift_mag valid, held until win_ready
//   win_ready  : downstream accept
//   overrun    : one-cycle pulse when a start was dropped
module spike_window_capture
    import spike_pkg::*;
#(
    parameter  int LEN           = 8,
    parameter  int MAX_SHIFT_MAG = 2,
    localparam int SW            = shift_w(MAX_SHIFT_MAG)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          spike_in,
    input  logic signed [SW-1:0]          shift_req,
    output logic                          start_rdy,
    output logic [0:LEN-1]                win,
    output logic [0:2*MAX_SHIFT_MAG]      shift_mag,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic                          overrun
);

    localparam int            CW     = $clog2(LEN);
    localparam int            MW     = 2 * MAX_SHIFT_MAG + 1;
    localparam logic [CW-1:0] LAST_T = CW'(LEN - 1);

    cap_state_t            state;
    cap_state_t            state_nxt;
    logic [CW-1:0]         cnt;
    logic [0:LEN-1]        acc;
    logic signed [SW-1:0]  shift_lat;
    logic [0:MW-1]         shift_onehot;
    logic                  accept;
    logic                  load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A handshake in HOLD frees the block in the same cycle, so a start
    // arriving alongside win_ready is taken without an idle bubble.
    always_comb begin
        state_nxt = state;
        start_rdy = 1'b0;
        accept    = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                start_rdy = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (cnt == LAST_T) begin
                    load      = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (win_ready) begin
                    start_rdy = 1'b1;
                    state_nxt = IDLE;
                    if (start) begin
                        accept    = 1'b1;
                        state_nxt = CAPTURE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    onehot_shift_encoder #(
        .MAX_SHIFT_MAG (MAX_SHIFT_MAG)
    ) u_encoder (
        .shift_in (shift_lat),
        .onehot   (shift_onehot)
    );

    // Samples enter at index 0 and move toward LEN-1, so the t=0 sample
    // finishes in win[LEN-1] and the last sample in win[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            shift_lat <= '0;
            win       <= '0;
            shift_mag <= '0;
            win_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= start & ~start_rdy;

            if (accept) begin
                cnt       <= CW'(1);
                acc       <= {spike_in, {(LEN-1){1'b0}}};
                shift_lat <= shift_req;
            end else if (state == CAPTURE) begin
                cnt <= cnt + CW'(1);
                acc <= {spike_in, acc[0:LEN-2]};
            end

            if (load) begin
                win       <= {spike_in, acc[0:LEN-2]};
                shift_mag <= shift_onehot;
                win_valid <= 1'b1;
            end else if (state == HOLD && win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule
